// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding for the bit-serial add/subtract controller.
package serial_add_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Full_Adder: one-bit full adder, the only arithmetic in the serial datapath.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ cin;
    assign c_out = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract, LSB first, one bit per clock through a shared Full_Adder.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] sa, sb, acc;
    logic [CNT_W-1:0] cnt;
    logic             carry, sum, c_out, last;

    Full_Adder u_fa (.a(sa[0]), .b(sb[0]), .cin(carry), .sum(sum), .c_out(c_out));

    assign last = cnt == CNT_W'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_RUN:   state_nxt = last ? S_DONE : S_RUN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = start ? S_RUN : S_IDLE;
        endcase
    end

    always_comb begin
        busy = state == S_RUN;
        done = state == S_DONE;
    end

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with sub.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa        <= '0;
            sb        <= '0;
            acc       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == S_IDLE && start) begin
            sa    <= op_a;
            sb    <= op_b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            sa    <= {1'b0, sa[WIDTH-1:1]};
            sb    <= {1'b0, sb[WIDTH-1:1]};
            acc   <= {sum, acc[WIDTH-1:1]};
            carry <= c_out;
            cnt   <= cnt + 1'b1;
            if (last) begin
                result    <= {sum, acc[WIDTH-1:1]};
                carry_out <= c_out;
                overflow  <= carry ^ c_out;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed vectors on an 8-bit instance plus an exhaustive sweep of a 4-bit instance.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, sub8 = 1'b0, busy8, done8, co8, ov8;
    logic [7:0] a8 = '0, b8 = '0, res8;
    logic       start4 = 1'b0, sub4 = 1'b0, busy4, done4, co4, ov4;
    logic [3:0] a4 = '0, b4 = '0, res4;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .op_a(a8), .op_b(b8),
        .busy(busy8), .done(done8), .result(res8), .carry_out(co8), .overflow(ov8)
    );
    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .op_a(a4), .op_b(b4),
        .busy(busy4), .done(done4), .result(res4), .carry_out(co4), .overflow(ov4)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        n_chk++;
        if ((done8 && busy8) || (done4 && busy4)) begin
            n_fail++;
            $display("FAIL done_busy_overlap: done8=%b busy8=%b done4=%b busy4=%b", done8, busy8, done4, busy4);
        end
    end

    // Issue one op, scramble inputs after acceptance, measure latency and busy cycles.
    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int bcnt);
        @(negedge clk);
        start8 = 1'b1; sub8 = s; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; sub8 = ~s; a8 = ~a; b8 = ~b;
        lat = 0; bcnt = 0;
        while (!done8 && lat < 20) begin
            if (busy8) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic count_done8(input int cycles, output int dn, output int bz);
        dn = 0; bz = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done8) dn++;
            if (busy8) bz++;
        end
    endtask

    typedef struct {
        string      name;
        logic       s;
        logic [7:0] a, b, r;
        logic       c, v;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, bcnt, dn, bz;
        vecs[0] = '{"add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{"add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{"sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{"add_00_00", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{"add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{"sub_00_00", 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{"sub_c3_5a", 1'b1, 8'hC3, 8'h5A, 8'h69, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_result", res8, 0);
        chk("reset_carry", co8, 0);
        chk("reset_ovf", ov8, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            op8(vecs[i].s, vecs[i].a, vecs[i].b, lat, bcnt);
            chk({vecs[i].name, "_latency"}, lat, 8);
            chk({vecs[i].name, "_busy_cycles"}, bcnt, 8);
            chk({vecs[i].name, "_result"}, res8, vecs[i].r);
            chk({vecs[i].name, "_carry"}, co8, vecs[i].c);
            chk({vecs[i].name, "_ovf"}, ov8, vecs[i].v);
            @(posedge clk);
        end

        // start pulses during RUN and during DONE must be ignored
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h5A; b8 = 8'h3C;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        start8 = 1'b1; sub8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore_first_done", done8, 1);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("ignore_done_back_idle", done8, 0);
        count_done8(15, dn, bz);
        chk("ignore_no_second_done", dn, 0);
        chk("ignore_no_busy", bz, 0);
        chk("ignore_result_held", res8, 8'h96);
        chk("ignore_ovf_held", ov8, 1);

        // reset during RUN cycle 4 aborts and clears outputs
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'hFF; b8 = 8'h01;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_before", busy8, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_result", res8, 0);
        chk("abort_carry", co8, 0);
        chk("abort_ovf", ov8, 0);
        count_done8(12, dn, bz);
        chk("abort_no_done", dn, 0);
        op8(1'b0, 8'h5A, 8'h3C, lat, bcnt);
        chk("after_abort_latency", lat, 8);
        chk("after_abort_result", res8, 8'h96);
        @(posedge clk);

        // reset wins over start on the same edge
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start8 = 1'b0;
        chk("rst_priority_busy", busy8, 0);
        count_done8(12, dn, bz);
        chk("rst_priority_no_run", bz, 0);

        // exhaustive 4-bit sweep against a golden {carry, sum}
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    logic [3:0] bb, r;
                    logic       c, v;
                    int         w;
                    bb = 4'(b) ^ {4{s[0]}};
                    {c, r} = 5'(a) + 5'(bb) + 5'(s);
                    v = (a[3] == bb[3]) && (r[3] != a[3]);
                    @(negedge clk);
                    start4 = 1'b1; sub4 = s[0]; a4 = 4'(a); b4 = 4'(b);
                    @(posedge clk); #1;
                    start4 = 1'b0; a4 = ~a4; b4 = ~b4;
                    w = 0;
                    while (!done4 && w < 10) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    chk($sformatf("w4_lat s%0d a%0h b%0h", s, a, b), w, 4);
                    chk($sformatf("w4_res s%0d a%0h b%0h", s, a, b), res4, r);
                    chk($sformatf("w4_c s%0d a%0h b%0h", s, a, b), co4, c);
                    chk($sformatf("w4_v s%0d a%0h b%0h", s, a, b), ov4, v);
                    @(posedge clk);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
